// File: rtl/flush_pkg.sv
// rtl/flush_pkg.sv - shared cause and FSM state encodings for flush_ctrl_multi
package flush_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_EXC  = 2'd1,
        CAUSE_INT  = 2'd2,
        CAUSE_MPR  = 2'd3
    } cause_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    // Exception outranks interrupt, which outranks a mispredict.
    function automatic cause_e pick_cause(input logic exc, input logic intr);
        cause_e c;
        if (exc) begin
            c = CAUSE_EXC;
        end else if (intr) begin
            c = CAUSE_INT;
        end else begin
            c = CAUSE_MPR;
        end
        return c;
    endfunction

endpackage

// File: rtl/fetch_outstanding_cnt.sv
// rtl/fetch_outstanding_cnt.sv - up/down count of in-flight I-fetch requests, floor-saturating at 0
module fetch_outstanding_cnt
    import flush_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] n_count,
    output logic             ready
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!inc && dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count   = cnt_q;
    assign n_count = cnt_d;
    assign ready   = (cnt_q < CNT_W'(MAX_OUTSTANDING));

endmodule

// File: rtl/flush_ctrl_multi.sv
// rtl/flush_ctrl_multi.sv - per-stage flush vector and wrong-path fetch response drain; FLUSH_STATS_EN adds cause counters
module flush_ctrl_multi
    import flush_pkg::*;
#(
    parameter int NUM_STAGES      = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  exception,
    input  logic                  interrupt,
    input  logic                  predict_error,
    input  logic [NUM_STAGES-1:0] stage_delay_slot,
    input  logic [NUM_STAGES-1:0] stage_valid,
    input  logic                  inst_req_fire,
    input  logic                  inst_resp_valid,
    output logic [NUM_STAGES-1:0] stage_flush,
    output logic                  resp_discard,
    output logic                  inst_req_ready,
    output logic                  drain_busy,
`ifdef FLUSH_STATS_EN
    output logic [31:0]           flush_stat_exc,
    output logic [31:0]           flush_stat_int,
    output logic [31:0]           flush_stat_mpr,
`endif
    output logic [1:0]            flush_cause
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic             ev;
    logic             hard;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] n_out;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    cause_e           cause_q, cause_d;

    assign ev   = exception | interrupt | predict_error;
    assign hard = exception | interrupt;

    fetch_outstanding_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_out_cnt (
        .clk     (clk),
        .resetn  (resetn),
        .inc     (inst_req_fire),
        .dec     (inst_resp_valid),
        .count   (outstanding),
        .n_count (n_out),
        .ready   (inst_req_ready)
    );

    // IF is flushed unconditionally; later stages only when IF holds a valid instruction.
    always_comb begin
        stage_flush = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            stage_flush[i] = hard | (predict_error & ~stage_delay_slot[i]);
            if (i != 0) begin
                stage_flush[i] = stage_flush[i] & stage_valid[0];
            end
        end
    end

    // A response in the flush cycle is already killed by stage_flush[0], so it never counts as a discard.
    always_comb begin
        state_d      = state_q;
        discard_d    = discard_q;
        cause_d      = cause_q;
        resp_discard = 1'b0;
        if (ev) begin
            cause_d   = pick_cause(exception, interrupt);
            discard_d = n_out;
            state_d   = (n_out != '0) ? ST_DRAIN : ST_IDLE;
        end else if ((state_q == ST_DRAIN) && inst_resp_valid) begin
            resp_discard = 1'b1;
            if (discard_q <= CNT_W'(1)) begin
                discard_d = '0;
                state_d   = ST_IDLE;
            end else begin
                discard_d = discard_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            discard_q <= '0;
            cause_q   <= CAUSE_NONE;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            cause_q   <= cause_d;
        end
    end

    assign drain_busy  = (state_q == ST_DRAIN);
    assign flush_cause = cause_q;

`ifdef FLUSH_STATS_EN
    logic [31:0] exc_cnt_q, exc_cnt_d;
    logic [31:0] int_cnt_q, int_cnt_d;
    logic [31:0] mpr_cnt_q, mpr_cnt_d;

    always_comb begin
        exc_cnt_d = exc_cnt_q;
        int_cnt_d = int_cnt_q;
        mpr_cnt_d = mpr_cnt_q;
        if (ev) begin
            case (cause_d)
                CAUSE_EXC: exc_cnt_d = exc_cnt_q + 32'd1;
                CAUSE_INT: int_cnt_d = int_cnt_q + 32'd1;
                CAUSE_MPR: mpr_cnt_d = mpr_cnt_q + 32'd1;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exc_cnt_q <= '0;
            int_cnt_q <= '0;
            mpr_cnt_q <= '0;
        end else begin
            exc_cnt_q <= exc_cnt_d;
            int_cnt_q <= int_cnt_d;
            mpr_cnt_q <= mpr_cnt_d;
        end
    end

    assign flush_stat_exc = exc_cnt_q;
    assign flush_stat_int = int_cnt_q;
    assign flush_stat_mpr = mpr_cnt_q;
`endif

endmodule

// File: tb/tb_flush_ctrl_multi.sv
// tb/tb_flush_ctrl_multi.sv - scoreboard bench for flush_ctrl_multi
module tb_flush_ctrl_multi;

    localparam int NS = 3;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          exception, interrupt, predict_error;
    logic [NS-1:0] stage_delay_slot, stage_valid;
    logic          inst_req_fire, inst_resp_valid;
    logic [NS-1:0] stage_flush;
    logic          resp_discard, inst_req_ready, drain_busy;
    logic [1:0]    flush_cause;
`ifdef FLUSH_STATS_EN
    logic [31:0]   flush_stat_exc, flush_stat_int, flush_stat_mpr;
`endif

    flush_ctrl_multi #(.NUM_STAGES(NS), .MAX_OUTSTANDING(MO)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .exception        (exception),
        .interrupt        (interrupt),
        .predict_error    (predict_error),
        .stage_delay_slot (stage_delay_slot),
        .stage_valid      (stage_valid),
        .inst_req_fire    (inst_req_fire),
        .inst_resp_valid  (inst_resp_valid),
        .stage_flush      (stage_flush),
        .resp_discard     (resp_discard),
        .inst_req_ready   (inst_req_ready),
        .drain_busy       (drain_busy),
`ifdef FLUSH_STATS_EN
        .flush_stat_exc   (flush_stat_exc),
        .flush_stat_int   (flush_stat_int),
        .flush_stat_mpr   (flush_stat_mpr),
`endif
        .flush_cause      (flush_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NS-1:0] sf;
        logic          rd;
        logic          ready;
        logic          busy;
        logic [1:0]    cause;
    } exp_t;

    exp_t exp_q[$];
    bit   inflight_q[$];   // one entry per outstanding request, 1 = wrong path
    logic [1:0] m_cause;
    int   m_stat[4];
    int   total = 0;
    int   bad   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endfunction

    task automatic zero_inputs();
        exception = 0; interrupt = 0; predict_error = 0;
        stage_delay_slot = '0; stage_valid = '0;
        inst_req_fire = 0; inst_resp_valid = 0;
    endtask

    task automatic model_reset();
        inflight_q.delete();
        exp_q.delete();
        m_cause = 2'd0;
        for (int k = 0; k < 4; k++) m_stat[k] = 0;
    endtask

    task automatic cycle(input logic e, input logic i, input logic m,
                         input logic [NS-1:0] ds, input logic [NS-1:0] sv,
                         input logic f, input logic r);
        exp_t x;
        bit   ev;
        @(posedge clk); #1;
        exception = e; interrupt = i; predict_error = m;
        stage_delay_slot = ds; stage_valid = sv;
        inst_req_fire = f; inst_resp_valid = r;
        ev = e | i | m;
        for (int k = 0; k < NS; k++) begin
            x.sf[k] = (e | i | (m & ~ds[k])) & ((k == 0) ? 1'b1 : sv[0]);
        end
        x.busy = 1'b0;
        foreach (inflight_q[k]) if (inflight_q[k]) x.busy = 1'b1;
        x.ready = (inflight_q.size() < MO);
        x.cause = m_cause;
        x.rd    = r && (inflight_q.size() > 0) && inflight_q[0] && !ev;
        exp_q.push_back(x);
        if (r && inflight_q.size() > 0) void'(inflight_q.pop_front());
        if (f) inflight_q.push_back(1'b0);
        if (ev) begin
            foreach (inflight_q[k]) inflight_q[k] = 1'b1;
            m_cause = e ? 2'd1 : (i ? 2'd2 : 2'd3);
            m_stat[m_cause]++;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, '0, '0, 0, 0);
    endtask

    task automatic drain_all();
        int guard = 0;
        while (inflight_q.size() > 0 && guard < 20) begin
            cycle(0, 0, 0, '0, '0, 0, 1);
            guard++;
        end
        chk("drain_all_bound", 32'(inflight_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (resetn && exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("stage_flush",    32'(stage_flush),    32'(x.sf));
            chk("resp_discard",   32'(resp_discard),   32'(x.rd));
            chk("inst_req_ready", 32'(inst_req_ready), 32'(x.ready));
            chk("drain_busy",     32'(drain_busy),     32'(x.busy));
            chk("flush_cause",    32'(flush_cause),    32'(x.cause));
            if (inst_req_fire) chk("fire_while_ready", 32'(inst_req_ready), 32'd1);
        end
    end

    initial begin
        zero_inputs();
        model_reset();
        resetn = 1'b0;
        #2;
        chk("rst_stage_flush", 32'(stage_flush),    32'd0);
        chk("rst_discard",     32'(resp_discard),   32'd0);
        chk("rst_ready",       32'(inst_req_ready), 32'd1);
        chk("rst_busy",        32'(drain_busy),     32'd0);
        chk("rst_cause",       32'(flush_cause),    32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        idle(1);

        // mispredict with IF/EX not delay slots, then exception+mispredict with all delay slots
        cycle(0, 0, 1, 3'b010, 3'b111, 0, 0);
        cycle(1, 0, 1, 3'b111, 3'b000, 0, 0);
        idle(1);

        // three in flight, interrupt while a fourth fires -> four discards
        cycle(0, 0, 0, '0, '0, 1, 0);
        cycle(0, 0, 0, '0, '0, 1, 0);
        cycle(0, 0, 0, '0, '0, 1, 0);
        cycle(0, 1, 0, '0, 3'b111, 1, 0);
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, '0, '0, 0, 1);
        cycle(0, 0, 0, '0, '0, 1, 0);
        cycle(0, 0, 0, '0, '0, 0, 1);
        idle(1);

        // re-flush inside DRAIN with a response and a fire in the same cycle
        cycle(0, 0, 0, '0, '0, 1, 0);
        cycle(0, 0, 0, '0, '0, 1, 0);
        cycle(0, 0, 1, '0, 3'b111, 0, 0);
        cycle(1, 0, 0, '0, 3'b111, 1, 1);
        cycle(0, 0, 0, '0, '0, 0, 1);
        cycle(0, 0, 0, '0, '0, 0, 1);
        idle(1);

        // fill to MAX_OUTSTANDING, then release one slot
        for (int k = 0; k < MO; k++) cycle(0, 0, 0, '0, '0, 1, 0);
        idle(1);
        cycle(0, 0, 0, '0, '0, 0, 1);
        idle(1);
        drain_all();

        // randomized traffic
        for (int n = 0; n < 500; n++) begin
            logic e, i, m, f, r;
            e = ($urandom_range(0, 24) == 0);
            i = ($urandom_range(0, 24) == 0);
            m = ($urandom_range(0, 9) == 0);
            f = ($urandom_range(0, 1) == 1) && (inflight_q.size() < MO);
            r = ($urandom_range(0, 1) == 1) && (inflight_q.size() > 0);
            cycle(e, i, m, NS'($urandom), NS'($urandom), f, r);
        end
        drain_all();
        idle(1);

`ifdef FLUSH_STATS_EN
        @(posedge clk); #1;
        chk("stat_exc", flush_stat_exc, 32'(m_stat[1]));
        chk("stat_int", flush_stat_int, 32'(m_stat[2]));
        chk("stat_mpr", flush_stat_mpr, 32'(m_stat[3]));
`endif

        // asynchronous reset in the middle of a 3-deep drain
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, '0, '0, 1, 0);
        cycle(0, 0, 1, '0, 3'b111, 0, 0);
        cycle(0, 0, 0, '0, '0, 0, 0);
        @(posedge clk); #1;
        zero_inputs();
        resetn = 1'b0;
        #1;
        chk("mid_rst_busy",  32'(drain_busy),     32'd0);
        chk("mid_rst_ready", 32'(inst_req_ready), 32'd1);
        chk("mid_rst_cause", 32'(flush_cause),    32'd0);
        chk("mid_rst_flush", 32'(stage_flush),    32'd0);
        model_reset();
        @(posedge clk); #1;
        resetn = 1'b1;
        cycle(0, 0, 0, '0, '0, 1, 0);
        cycle(0, 0, 0, '0, '0, 0, 1);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
